// File: rtl/plateau_finder.sv
// IDELAY tap scanner: walks taps 0..kMaxTap through a req/ack stability probe,
// tracks the longest contiguous stable run and reports its center and length.
module plateau_finder #(
    parameter int kCNTVALUEbit = 9,
    parameter int kNumTaps     = 32,
    parameter int kMaxTap      = 511
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    startScan,
    input  logic [kNumTaps-1:0]     plateauThreshold,
    output logic [kCNTVALUEbit-1:0] tapValue,
    output logic                    tapReq,
    input  logic                    tapAck,
    input  logic                    tapStable,
    output logic                    scanBusy,
    output logic                    scanDone,
    output logic                    scanFound,
    output logic [kCNTVALUEbit-1:0] centerTap,
    output logic [kCNTVALUEbit:0]   bestLength
);

    localparam int LW = kCNTVALUEbit + 1;
    localparam int CW = (kNumTaps > LW) ? kNumTaps : LW;
    localparam logic [kCNTVALUEbit-1:0] MAX_TAP = kCNTVALUEbit'(kMaxTap);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_EVAL, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [kCNTVALUEbit-1:0] tap_q;
    logic [kNumTaps-1:0]     thr_q;
    logic                    stable_q;
    logic                    run_open_q;
    logic [kCNTVALUEbit-1:0] cur_start_q;
    logic [LW-1:0]           cur_len_q;
    logic [kCNTVALUEbit-1:0] best_start_q;
    logic [LW-1:0]           best_len_q;
    logic                    found_q;
    logic [kCNTVALUEbit-1:0] center_q;
    logic [LW-1:0]           blen_q;

    logic                    last_tap;
    logic [LW-1:0]           ext_len, cand_len, best_len_d, half_len;
    logic [kCNTVALUEbit-1:0] ext_start, cand_start, best_start_d, center_d;
    logic                    closing;
    logic [kNumTaps-1:0]     eff_thr;
    logic                    found_d;

    always_comb begin
        state_d  = state_q;
        tapReq   = 1'b0;
        scanBusy = 1'b0;
        scanDone = 1'b0;
        case (state_q)
            S_IDLE: if (startScan) state_d = S_REQ;
            S_REQ: begin
                tapReq   = 1'b1;
                scanBusy = 1'b1;
                if (tapAck) state_d = S_EVAL;
            end
            S_EVAL: begin
                scanBusy = 1'b1;
                state_d  = last_tap ? S_DONE : S_REQ;
            end
            S_DONE: begin
                scanDone = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A stable tap either opens or extends the run; the last tap forces the
    // run shut so a plateau touching kMaxTap is still scored.
    always_comb begin
        last_tap   = (tap_q == MAX_TAP);
        ext_len    = run_open_q ? cur_len_q + LW'(1) : LW'(1);
        ext_start  = run_open_q ? cur_start_q : tap_q;
        cand_len   = stable_q ? ext_len : cur_len_q;
        cand_start = stable_q ? ext_start : cur_start_q;
        closing    = (run_open_q && !stable_q) || (stable_q && last_tap);
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        if (closing && (cand_len > best_len_q)) begin
            best_len_d   = cand_len;
            best_start_d = cand_start;
        end
    end

    always_comb begin
        half_len = (best_len_d - LW'(1)) >> 1;
        center_d = (best_len_d == '0) ? '0
                 : best_start_d + half_len[kCNTVALUEbit-1:0];
        eff_thr  = (thr_q == '0) ? kNumTaps'(1) : thr_q;
        found_d  = (CW'(best_len_d) >= CW'(eff_thr));
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= S_IDLE;
            tap_q        <= '0;
            thr_q        <= '0;
            stable_q     <= 1'b0;
            run_open_q   <= 1'b0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            found_q      <= 1'b0;
            center_q     <= '0;
            blen_q       <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (startScan) begin
                    thr_q        <= plateauThreshold;
                    tap_q        <= '0;
                    stable_q     <= 1'b0;
                    run_open_q   <= 1'b0;
                    cur_start_q  <= '0;
                    cur_len_q    <= '0;
                    best_start_q <= '0;
                    best_len_q   <= '0;
                end
                S_REQ: if (tapAck) stable_q <= tapStable;
                S_EVAL: begin
                    best_len_q   <= best_len_d;
                    best_start_q <= best_start_d;
                    if (stable_q) begin
                        cur_len_q   <= ext_len;
                        cur_start_q <= ext_start;
                        run_open_q  <= !last_tap;
                    end else begin
                        cur_len_q  <= '0;
                        run_open_q <= 1'b0;
                    end
                    // Results load on the way into DONE so they are valid
                    // alongside the scanDone pulse and hold until the next one.
                    if (last_tap) begin
                        found_q  <= found_d;
                        center_q <= center_d;
                        blen_q   <= best_len_d;
                    end else begin
                        tap_q <= tap_q + kCNTVALUEbit'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign tapValue   = tap_q;
    assign scanFound  = found_q;
    assign centerTap  = center_q;
    assign bestLength = blen_q;

endmodule

// File: tb/tb_plateau_finder.sv
// Randomized + directed bench for plateau_finder with a run-list reference model
// and a scoreboard popped by an output monitor on every scanDone.
module tb_plateau_finder;
    localparam int NT = 512;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        startScan;
    logic [31:0] plateauThreshold;
    logic [8:0]  tapValue;
    logic        tapReq;
    logic        tapAck;
    logic        tapStable;
    logic        scanBusy;
    logic        scanDone;
    logic        scanFound;
    logic [8:0]  centerTap;
    logic [9:0]  bestLength;

    plateau_finder dut (
        .CLK(CLK), .RSTn(RSTn), .startScan(startScan),
        .plateauThreshold(plateauThreshold), .tapValue(tapValue),
        .tapReq(tapReq), .tapAck(tapAck), .tapStable(tapStable),
        .scanBusy(scanBusy), .scanDone(scanDone), .scanFound(scanFound),
        .centerTap(centerTap), .bestLength(bestLength)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit found;
        int len;
        int center;
    } exp_t;

    bit   stab[NT];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   spur_req = 0;
    int   lat_min = 1;
    int   lat_max = 1;
    bit   r_found = 0;
    int   r_len = 0;
    int   r_center = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Reference: list the maximal stable runs, keep the first longest one.
    function automatic exp_t model(input longint thr);
        exp_t e;
        int   rs[$];
        int   rl[$];
        int   i = 0;
        int   bl = 0;
        int   bs = 0;
        while (i < NT) begin
            if (stab[i]) begin
                int s = i;
                while (i < NT && stab[i]) i++;
                rs.push_back(s);
                rl.push_back(i - s);
            end else i++;
        end
        foreach (rl[k]) if (rl[k] > bl) begin bl = rl[k]; bs = rs[k]; end
        e.len    = bl;
        e.center = (bl == 0) ? 0 : bs + (bl - 1) / 2;
        e.found  = (longint'(bl) >= ((thr == 0) ? 64'd1 : thr));
        return e;
    endfunction

    // Responder: acks each request after a random latency in [lat_min, lat_max].
    initial begin
        int cnt;
        int lat;
        int spur_seen;
        cnt = 0; lat = 1; spur_seen = 0;
        tapAck = 1'b0; tapStable = 1'b0;
        forever begin
            @(posedge CLK); #1;
            tapAck = 1'b0;
            if (!RSTn) cnt = 0;
            else if (spur_req != spur_seen) begin
                spur_seen = spur_req;
                tapAck = 1'b1; tapStable = 1'b1;
            end else if (tapReq) begin
                if (cnt >= lat) begin
                    tapAck = 1'b1;
                    tapStable = stab[tapValue];
                    cnt = 0;
                    lat = $urandom_range(lat_max, lat_min);
                end else cnt++;
            end
        end
    end

    // Monitor: handshake/tap-order checks and scoreboard compare on scanDone.
    initial begin
        bit         p_req, p_ack, p_done;
        logic [8:0] p_tap;
        int         exp_tap;
        exp_t       e;
        p_req = 0; p_ack = 0; p_done = 0; p_tap = '0; exp_tap = 0;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                exp_tap = 0; p_req = 0; p_ack = 0; p_done = 0;
                continue;
            end
            if (p_req && p_ack) chk("req_low_after_ack", tapReq, 0);
            if (tapReq && !p_req) begin
                chk("tap_step", tapValue, exp_tap);
                exp_tap++;
            end else if (tapReq && p_req) chk("tap_hold", tapValue, p_tap);
            if (scanDone) begin
                chk("done_width", p_done, 0);
                chk("busy_in_done", scanBusy, 0);
                chk("taps_covered", exp_tap, NT);
                done_cnt++;
                exp_tap = 0;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done got pulse want none (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("scanFound", scanFound, e.found);
                    chk("bestLength", bestLength, e.len);
                    chk("centerTap", centerTap, e.center);
                end
            end
            p_req = tapReq; p_ack = tapAck; p_done = scanDone; p_tap = tapValue;
        end
    end

    task automatic clear_stab();
        for (int i = 0; i < NT; i++) stab[i] = 0;
    endtask

    task automatic set_range(input int a, input int b);
        for (int i = a; i <= b; i++) stab[i] = 1;
    endtask

    task automatic rand_stab();
        bit cur;
        cur = 1'($urandom_range(1, 0));
        for (int i = 0; i < NT; i++) begin
            if ($urandom_range(15, 0) == 0) cur = !cur;
            stab[i] = cur;
        end
    endtask

    task automatic start_scan(input longint thr, input bit expect_done);
        if (expect_done) sb.push_back(model(thr));
        plateauThreshold = thr[31:0];
        @(posedge CLK); #1;
        startScan = 1'b1;
        @(posedge CLK); #1;
        startScan = 1'b0;
        chk("busy_after_start", scanBusy, 1);
        chk("hold_found", scanFound, r_found);
        chk("hold_len", bestLength, r_len);
        chk("hold_center", centerTap, r_center);
    endtask

    task automatic wait_done();
        int start;
        int n;
        start = done_cnt; n = 0;
        while (done_cnt == start && n < 4000) begin @(posedge CLK); n++; end
        chk("scan_timeout", done_cnt != start, 1);
    endtask

    task automatic run_scan(input longint thr);
        exp_t e;
        e = model(thr);
        start_scan(thr, 1);
        wait_done();
        r_found = e.found; r_len = e.len; r_center = e.center;
        repeat (2) @(posedge CLK);
    endtask

    initial begin
        longint thr;
        int     n;
        int     d0;
        RSTn = 1'b0; startScan = 1'b0; plateauThreshold = '0;
        clear_stab();
        #22;
        chk("rst_tapValue", tapValue, 0);
        chk("rst_tapReq", tapReq, 0);
        chk("rst_busy", scanBusy, 0);
        chk("rst_done", scanDone, 0);
        chk("rst_found", scanFound, 0);
        chk("rst_center", centerTap, 0);
        chk("rst_len", bestLength, 0);
        @(posedge CLK); #1; RSTn = 1'b1;
        repeat (2) @(posedge CLK);

        clear_stab(); set_range(100, 199); run_scan(40);
        clear_stab(); set_range(10, 29); set_range(300, 339); run_scan(40); run_scan(41);
        clear_stab(); set_range(50, 59); set_range(400, 409); run_scan(10);
        clear_stab(); set_range(500, 511); run_scan(12);
        clear_stab(); run_scan(5);
        clear_stab(); stab[7] = 1; run_scan(0);
        clear_stab(); set_range(0, 511); run_scan(64'h0001_0000);

        // Spurious ack while idle must not start anything or move results.
        spur_req++;
        repeat (4) @(posedge CLK); #1;
        chk("spur_busy", scanBusy, 0);
        chk("spur_req", tapReq, 0);
        chk("spur_len", bestLength, r_len);
        chk("spur_found", scanFound, r_found);

        // startScan mid-scan with a different threshold is ignored.
        lat_min = 0; lat_max = 2;
        rand_stab();
        thr = 20;
        sb.push_back(model(thr));
        start_scan(thr, 0);
        repeat (300) @(posedge CLK); #1;
        plateauThreshold = 32'd0; startScan = 1'b1;
        @(posedge CLK); #1; startScan = 1'b0;
        wait_done();
        begin exp_t e; e = model(thr); r_found = e.found; r_len = e.len; r_center = e.center; end
        repeat (2) @(posedge CLK);

        // Reset mid-scan at tap 250: immediate abort, no scanDone.
        clear_stab(); set_range(200, 260);
        start_scan(8, 0);
        n = 0;
        while (tapValue != 9'd250 && n < 3000) begin @(posedge CLK); #1; n++; end
        chk("reach_tap250", tapValue, 250);
        d0 = done_cnt;
        RSTn = 1'b0; #1;
        chk("abort_tapValue", tapValue, 0);
        chk("abort_tapReq", tapReq, 0);
        chk("abort_busy", scanBusy, 0);
        chk("abort_done", scanDone, 0);
        chk("abort_found", scanFound, 0);
        chk("abort_center", centerTap, 0);
        chk("abort_len", bestLength, 0);
        repeat (3) @(posedge CLK); #1;
        RSTn = 1'b1;
        r_found = 0; r_len = 0; r_center = 0;
        repeat (3) @(posedge CLK);
        chk("abort_no_done", done_cnt, d0);
        run_scan(8);

        for (int k = 0; k < 8; k++) begin
            rand_stab();
            thr = ($urandom_range(3, 0) == 0) ? longint'($urandom_range(600, 0))
                                              : longint'($urandom_range(80, 0));
            run_scan(thr);
        end

        repeat (5) @(posedge CLK);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/plateau_finder.md
PLATEAU_FINDER -- requirements
Module: plateau_finder

Interface
REQ-001 Parameter kCNTVALUEbit, default 9: width of the tap value and of all tap-domain counters.
REQ-002 Parameter kNumTaps, default 32: width of the plateauThreshold input.
REQ-003 Parameter kMaxTap, default 511: last tap scanned; scan covers taps 0..kMaxTap.
REQ-004 CLK  in  1  single clock; all logic is rising-edge.
REQ-005 RSTn  in  1  asynchronous, active-low reset.
REQ-006 startScan  in  1  one-cycle scan start pulse.
REQ-007 plateauThreshold  in  kNumTaps  minimum stable run length in taps; sampled at scan start.
REQ-008 tapValue  out  kCNTVALUEbit  tap under test, driven to the IDELAY load logic.
REQ-009 tapReq  out  1  request: "load tapValue and judge stability".
REQ-010 tapAck  in  1  responder completion strobe; tapStable is valid in the same cycle.
REQ-011 tapStable  in  1  1 = data was stable at tapValue.
REQ-012 scanBusy  out  1  high while a scan is in progress.
REQ-013 scanDone  out  1  one-cycle pulse when results become valid.
REQ-014 scanFound  out  1  a run of at least the threshold length exists.
REQ-015 centerTap  out  kCNTVALUEbit  center of the best run.
REQ-016 bestLength  out  kCNTVALUEbit+1  length of the best run.

Function
REQ-017 The FSM shall have the states IDLE, REQ, EVAL and DONE.
REQ-018 IDLE: on startScan=1, the block shall latch plateauThreshold, clear all run registers and go to REQ with tapValue=0.
REQ-019 REQ: tapReq shall be 1 and tapValue stable; the FSM shall stay in REQ until tapAck=1, then capture tapStable and go to EVAL.
- tapReq is 0 in the cycle after the ack.
REQ-020 EVAL, one cycle: the run update of REQ-022 applies.
- If tapValue==kMaxTap: go to DONE.
- Otherwise: tapValue increments by 1 and the FSM returns to REQ.
REQ-021 DONE, one cycle: scanDone=1, result outputs update in the same cycle, then IDLE.
REQ-022 Run tracking:
- stable=1 with no open run: curStart=tapValue, curLen=1.
- stable=1 with an open run: curLen+1.
- stable=0: the open run closes.
- At kMaxTap, an open run closes after being counted.
REQ-023 Closing a run: if curLen > bestLen (strict), bestStart=curStart and bestLen=curLen. Ties keep the earlier run.
REQ-024 centerTap shall equal bestStart + ((bestLen-1)>>1), rounded down.
REQ-025 Threshold compare: threshold 0 is treated as 1; any threshold > kMaxTap+1 means scanFound=0. The comparison is unsigned at full kNumTaps width, with no truncation.
REQ-026 scanFound shall be 1 iff bestLen >= effective threshold.
- If no stable tap was seen: bestLen=0, centerTap=0, scanFound=0.
REQ-027 scanBusy shall be 1 in REQ and EVAL, and 0 in IDLE and DONE.
REQ-028 startScan outside IDLE shall be ignored; tapAck outside REQ shall be ignored.
REQ-029 Result outputs shall hold until the DONE of the next scan; a new scan does not clear them early.
REQ-030 Minimum scan time: (kMaxTap+1) x (ack latency + 2) cycles + 1 DONE cycle.

Reset
REQ-031 While RSTn=0, regardless of state:
- FSM=IDLE.
- tapValue=0, tapReq=0, scanBusy=0, scanDone=0, scanFound=0.
- centerTap=0, bestLength=0.
- Latched threshold and run registers = 0.
REQ-032 Reset asserted mid-scan shall abort immediately, with no scanDone pulse; the next scan after release starts from tap 0.

Verification
REQ-033 threshold=40, tapStable=1 for taps 100..199 only, ack 1 cycle after each req:
- scanDone once, scanFound=1, bestLength=100, centerTap=149.
- Checker: tapReq/tapAck handshake, tapValue increments by exactly 1 per tap, tapReq low the cycle after each ack.
REQ-034 threshold=40, stable runs 10..29 (20) and 300..339 (40) -> bestLength=40, centerTap=319, scanFound=1. Second run: threshold=41 -> scanFound=0, bestLength=40.
REQ-035 Two equal runs 50..59 and 400..409, threshold=10 -> centerTap=54 (earlier run kept), scanFound=1.
REQ-036 Stable at taps 500..511 (run open at end), threshold=12 -> bestLength=12, centerTap=505, scanFound=1. All taps unstable -> scanFound=0, bestLength=0, centerTap=0.
REQ-037 Threshold boundaries:
- threshold=0 with a single stable tap 7 -> scanFound=1, centerTap=7.
- threshold=0x00010000 with all 512 taps stable -> scanFound=0, bestLength=512.
REQ-038 Reset and ignored inputs:
- RSTn low at tap 250 -> all outputs 0 within the same cycle, no scanDone; after release, startScan restarts the scan at tapValue=0.
- startScan pulsed during a scan -> no effect.
- Spurious tapAck in IDLE -> no effect.
